// File: rtl/i2c_slave_regif_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regif_if
// Description : I2C pad and register-bus signal bundle for i2c_slave_regif.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_regif_if;
    logic        i2c_addr_2byte;
    logic        scl_pad_i;
    logic        sda_pad_i;
    logic        sda_pad_o;
    logic        sda_padoen_o;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_rdata;
    logic        busy;

    modport slave (
        input  i2c_addr_2byte, scl_pad_i, sda_pad_i, reg_rdata,
        output sda_pad_o, sda_padoen_o, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output i2c_addr_2byte, scl_pad_i, sda_pad_i, reg_rdata,
        input  sda_pad_o, sda_padoen_o, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_regif.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regif
// Description : I2C target at a fixed 7-bit address with 8/16-bit register
//               addressing and a strobed register-bus back end.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regif #(
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter int         FILTER_LEN = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    i2c_slave_regif_if.slave   bus
);

    localparam logic [3:0] c_ST_IDLE    = 4'd0;
    localparam logic [3:0] c_ST_DEVADR  = 4'd1;
    localparam logic [3:0] c_ST_ACK_DEV = 4'd2;
    localparam logic [3:0] c_ST_REGHI   = 4'd3;
    localparam logic [3:0] c_ST_ACK_RHI = 4'd4;
    localparam logic [3:0] c_ST_REGLO   = 4'd5;
    localparam logic [3:0] c_ST_ACK_RLO = 4'd6;
    localparam logic [3:0] c_ST_WDATA   = 4'd7;
    localparam logic [3:0] c_ST_ACK_W   = 4'd8;
    localparam logic [3:0] c_ST_RDATA   = 4'd9;
    localparam logic [3:0] c_ST_MACK    = 4'd10;
    localparam logic [3:0] c_ST_IGNORE  = 4'd11;

    logic [1:0]            r_scl_sync;
    logic [1:0]            r_sda_sync;
    logic [FILTER_LEN-1:0] r_scl_hist;
    logic [FILTER_LEN-1:0] r_sda_hist;
    logic [FILTER_LEN-1:0] w_scl_hist_nxt;
    logic [FILTER_LEN-1:0] w_sda_hist_nxt;
    logic                  r_scl_f;
    logic                  r_sda_f;
    logic                  r_scl_d;
    logic                  r_sda_d;

    logic [3:0]            r_state;
    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_shift;
    logic                  r_rw;
    logic                  r_sda_oen;
    logic [15:0]           r_reg_addr;
    logic [7:0]            r_reg_wdata;
    logic                  r_reg_we;
    logic                  r_reg_re;
    logic                  r_busy;

    generate
        if (FILTER_LEN > 1) begin : g_hist_shift
            assign w_scl_hist_nxt = {r_scl_hist[FILTER_LEN-2:0], r_scl_sync[1]};
            assign w_sda_hist_nxt = {r_sda_hist[FILTER_LEN-2:0], r_sda_sync[1]};
        end else begin : g_hist_single
            assign w_scl_hist_nxt = r_scl_sync[1];
            assign w_sda_hist_nxt = r_sda_sync[1];
        end
    endgenerate

    // Filtered level only changes once FILTER_LEN synced samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], bus.scl_pad_i};
            r_sda_sync <= {r_sda_sync[0], bus.sda_pad_i};
            r_scl_hist <= w_scl_hist_nxt;
            r_sda_hist <= w_sda_hist_nxt;
            if (&r_scl_hist)       r_scl_f <= 1'b1;
            else if (~|r_scl_hist) r_scl_f <= 1'b0;
            if (&r_sda_hist)       r_sda_f <= 1'b1;
            else if (~|r_sda_hist) r_sda_f <= 1'b0;
            r_scl_d    <= r_scl_f;
            r_sda_d    <= r_sda_f;
        end
    end

    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;
    logic        w_last_bit;
    logic [7:0]  w_byte;
    logic [15:0] w_addr_inc;

    assign w_scl_rise = r_scl_f & ~r_scl_d;
    assign w_scl_fall = ~r_scl_f & r_scl_d;
    assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
    assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_byte     = {r_shift, r_sda_f};
    assign w_addr_inc = bus.i2c_addr_2byte ? (r_reg_addr + 16'd1)
                                           : {8'h00, r_reg_addr[7:0] + 8'd1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_rw        <= 1'b0;
            r_sda_oen   <= 1'b1;
            r_reg_addr  <= 16'd0;
            r_reg_wdata <= 8'd0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_reg_we <= 1'b0;
            r_reg_re <= 1'b0;
            if (w_start) begin
                r_state   <= c_ST_DEVADR;
                r_bit_cnt <= 3'd0;
                r_sda_oen <= 1'b1;
                r_busy    <= 1'b0;
            end else if (w_stop) begin
                r_state   <= c_ST_IDLE;
                r_sda_oen <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_DEVADR: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            if (w_byte[7:1] == DEV_ADDR) begin
                                r_rw    <= w_byte[0];
                                r_busy  <= 1'b1;
                                r_state <= c_ST_ACK_DEV;
                            end else begin
                                r_state <= c_ST_IGNORE;
                            end
                        end
                    end
                    c_ST_REGHI: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            r_reg_addr[15:8] <= w_byte;
                            r_state          <= c_ST_ACK_RHI;
                        end
                    end
                    c_ST_REGLO: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            r_reg_addr[7:0] <= w_byte;
                            if (!bus.i2c_addr_2byte) r_reg_addr[15:8] <= 8'h00;
                            r_state <= c_ST_ACK_RLO;
                        end
                    end
                    c_ST_WDATA: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            r_reg_wdata <= w_byte;
                            r_reg_we    <= 1'b1;
                            r_state     <= c_ST_ACK_W;
                        end
                    end
                    // ACK phases: first SCL fall pulls SDA low, the next one ends the ACK.
                    c_ST_ACK_DEV: if (w_scl_fall) begin
                        if (r_sda_oen) begin
                            r_sda_oen <= 1'b0;
                        end else if (r_rw) begin
                            r_reg_re <= 1'b1;
                            r_state  <= c_ST_RDATA;
                        end else begin
                            r_sda_oen <= 1'b1;
                            r_state   <= bus.i2c_addr_2byte ? c_ST_REGHI : c_ST_REGLO;
                        end
                    end
                    c_ST_ACK_RHI: if (w_scl_fall) begin
                        if (r_sda_oen) begin
                            r_sda_oen <= 1'b0;
                        end else begin
                            r_sda_oen <= 1'b1;
                            r_state   <= c_ST_REGLO;
                        end
                    end
                    c_ST_ACK_RLO: if (w_scl_fall) begin
                        if (r_sda_oen) begin
                            r_sda_oen <= 1'b0;
                        end else begin
                            r_sda_oen <= 1'b1;
                            r_state   <= c_ST_WDATA;
                        end
                    end
                    c_ST_ACK_W: if (w_scl_fall) begin
                        if (r_sda_oen) begin
                            r_sda_oen <= 1'b0;
                        end else begin
                            r_sda_oen  <= 1'b1;
                            r_reg_addr <= w_addr_inc;
                            r_state    <= c_ST_WDATA;
                        end
                    end
                    // Read data is captured the clk after reg_re; SDA stays as-is until then.
                    c_ST_RDATA: begin
                        if (r_reg_re) begin
                            r_shift   <= bus.reg_rdata[6:0];
                            r_sda_oen <= bus.reg_rdata[7];
                            r_bit_cnt <= 3'd0;
                        end else if (w_scl_fall) begin
                            if (w_last_bit) begin
                                r_sda_oen <= 1'b1;
                                r_bit_cnt <= 3'd0;
                                r_state   <= c_ST_MACK;
                            end else begin
                                r_sda_oen <= r_shift[6];
                                r_shift   <= {r_shift[5:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    c_ST_MACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_f) r_state   <= c_ST_IGNORE;
                            else         r_bit_cnt <= 3'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 3'd1)) begin
                            r_reg_addr <= w_addr_inc;
                            r_reg_re   <= 1'b1;
                            r_bit_cnt  <= 3'd0;
                            r_state    <= c_ST_RDATA;
                        end
                    end
                    c_ST_IDLE, c_ST_IGNORE: begin
                        r_sda_oen <= 1'b1;
                    end
                    default: begin
                        r_state   <= c_ST_IDLE;
                        r_sda_oen <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.sda_pad_o    = 1'b0;
    assign bus.sda_padoen_o = r_sda_oen;
    assign bus.reg_addr     = r_reg_addr;
    assign bus.reg_wdata    = r_reg_wdata;
    assign bus.reg_we       = r_reg_we;
    assign bus.reg_re       = r_reg_re;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regif.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_regif
// Description : Bit-banged I2C master with scoreboarded register strobes,
//               ACK bits and read bytes for i2c_slave_regif.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regif;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } we_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic mode2 = 1'b1;
    logic sda_line;

    int n_checks = 0;
    int n_fail   = 0;

    we_t         exp_we_q[$];
    logic [15:0] exp_re_q[$];
    logic [7:0]  exp_rx_q[$];
    logic [7:0]  obs_rx_q[$];

    always #5 clk = ~clk;

    i2c_slave_regif_if bus();

    assign sda_line           = m_sda & (bus.sda_padoen_o | bus.sda_pad_o);
    assign bus.scl_pad_i      = m_scl;
    assign bus.sda_pad_i      = sda_line;
    assign bus.i2c_addr_2byte = mode2;
    assign bus.reg_rdata      = (bus.reg_addr == 16'h1234) ? 8'hA5 :
                                (bus.reg_addr == 16'h1235) ? 8'h5A : 8'h00;

    i2c_slave_regif #(.DEV_ADDR(7'h3C), .FILTER_LEN(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pops expectations whenever the DUT presents a strobe or a bus bit/byte.
    always @(negedge clk) begin : mon
        we_t         e;
        logic [15:0] ra;
        logic [7:0]  o;
        if (rst_n) begin
            if (bus.reg_we === 1'b1) begin
                if (exp_we_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL we_unexpected: got addr %h data %h expected no write", bus.reg_addr, bus.reg_wdata);
                end else begin
                    e = exp_we_q.pop_front();
                    check("we_addr", 32'(bus.reg_addr), 32'(e.addr));
                    check("we_data", 32'(bus.reg_wdata), 32'(e.data));
                    check("we_re_excl", 32'(bus.reg_re), 32'd0);
                end
            end
            if (bus.reg_re === 1'b1) begin
                if (exp_re_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL re_unexpected: got addr %h expected no read", bus.reg_addr);
                end else begin
                    ra = exp_re_q.pop_front();
                    check("re_addr", 32'(bus.reg_addr), 32'(ra));
                end
            end
            if (obs_rx_q.size() > 0) begin
                o = obs_rx_q.pop_front();
                if (exp_rx_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rx_unexpected: got %h expected nothing", o);
                end else begin
                    check("rx_bit_or_byte", 32'(o), 32'(exp_rx_q.pop_front()));
                end
            end
        end
    end

    task automatic qwait();
        repeat (8) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait(); qwait();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    qwait();
        m_scl = 1'b1; qwait(); qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        b = sda_line; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        logic a;
        exp_rx_q.push_back({7'd0, exp_ack});
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        obs_rx_q.push_back({7'd0, a});
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic mack);
        logic [7:0] d;
        logic       bt;
        d = 8'h00;
        exp_rx_q.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            read_bit(bt);
            d = {d[6:0], bt};
        end
        obs_rx_q.push_back(d);
        write_bit(mack);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected run to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        repeat (4) @(negedge clk);
        check("rst_padoen", 32'(bus.sda_padoen_o), 32'd1);
        check("rst_addr",   32'(bus.reg_addr),     32'd0);
        check("rst_wdata",  32'(bus.reg_wdata),    32'd0);
        check("rst_we",     32'(bus.reg_we),       32'd0);
        check("rst_re",     32'(bus.reg_re),       32'd0);
        check("rst_busy",   32'(bus.busy),         32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // 2-byte single write
        mode2 = 1'b1;
        exp_we_q.push_back('{addr: 16'h3008, data: 8'h82});
        i2c_start();
        send_byte(8'h78, 1'b0);
        check("busy_after_match", 32'(bus.busy), 32'd1);
        send_byte(8'h30, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h82, 1'b0);
        i2c_stop();
        check("busy_after_stop", 32'(bus.busy), 32'd0);

        // Burst write
        exp_we_q.push_back('{addr: 16'h3000, data: 8'h11});
        exp_we_q.push_back('{addr: 16'h3001, data: 8'h22});
        exp_we_q.push_back('{addr: 16'h3002, data: 8'h33});
        i2c_start();
        send_byte(8'h78, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        i2c_stop();

        // Random read with repeated START
        exp_re_q.push_back(16'h1234);
        exp_re_q.push_back(16'h1235);
        i2c_start();
        send_byte(8'h78, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        i2c_start();
        send_byte(8'h79, 1'b0);
        recv_byte(8'hA5, 1'b0);
        recv_byte(8'h5A, 1'b1);
        i2c_stop();
        check("busy_after_read", 32'(bus.busy), 32'd0);

        // Wrong device address
        i2c_start();
        send_byte(8'h7A, 1'b1);
        check("busy_wrong_addr", 32'(bus.busy), 32'd0);
        i2c_stop();

        // 1-byte mode wrap
        mode2 = 1'b0;
        exp_we_q.push_back('{addr: 16'h00FF, data: 8'hAA});
        exp_we_q.push_back('{addr: 16'h0000, data: 8'hBB});
        i2c_start();
        send_byte(8'h78, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        i2c_stop();

        // Aborted data byte, then reset mid read byte
        i2c_start();
        send_byte(8'h78, 1'b0);
        send_byte(8'h10, 1'b0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        check("busy_after_abort", 32'(bus.busy), 32'd0);

        exp_re_q.push_back(16'h0034);
        i2c_start();
        send_byte(8'h78, 1'b0);
        send_byte(8'h34, 1'b0);
        i2c_start();
        send_byte(8'h79, 1'b0);
        read_bit(b); read_bit(b); read_bit(b);
        check("read_bit_driving", 32'(bus.sda_padoen_o), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_padoen", 32'(bus.sda_padoen_o), 32'd1);
        check("async_rst_busy",   32'(bus.busy),         32'd0);
        check("async_rst_addr",   32'(bus.reg_addr),     32'd0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);

        check("we_left", 32'(exp_we_q.size()), 32'd0);
        check("re_left", 32'(exp_re_q.size()), 32'd0);
        check("rx_left", 32'(exp_rx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
